// File: rtl/run_sequencer_pkg.sv
// Shared types and constants for the run sequencer: FSM states, LFSR taps and
// default parameter values.
package run_sequencer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPreload,
        StStart,
        StRun,
        StDone,
        StAbort
    } state_e;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form, shifting left
    localparam logic [7:0] LfsrTapMask = 8'hB8;

    localparam int unsigned DefPreloadLen  = 64;
    localparam int unsigned DefStartCycles = 2;
    localparam int unsigned DefTimeout     = 4096;
    localparam logic [7:0]  DefSeed        = 8'hA5;

    function automatic logic [7:0] lfsr_step(input logic [7:0] value);
        return {value[6:0], ^(value & LfsrTapMask)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load of the seed and single-step advance.
module lfsr8
    import run_sequencer_pkg::*;
#(
    parameter logic [7:0] SEED = DefSeed
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Load,
    input  logic       Advance,
    output logic [7:0] Value
);

    logic [7:0] value_d;

    always_comb begin
        value_d = Value;
        if (Load) begin
            value_d = SEED;
        end else if (Advance) begin
            value_d = lfsr_step(Value);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Value <= SEED;
        end else begin
            Value <= value_d;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Sequences processor runs: optional data-memory preload, start pulse, then waits
// for Ack or a per-program timeout, for up to four programs back-to-back.
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int unsigned PRELOAD_LEN  = DefPreloadLen,
    parameter int unsigned START_CYCLES = DefStartCycles,
    parameter int unsigned TIMEOUT      = DefTimeout,
    parameter logic [7:0]  SEED         = DefSeed
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Go,
    input  logic [1:0]  ProgCount,
    input  logic        Ack,
    output logic        Start,
    output logic        MemWrEn,
    output logic [7:0]  MemAddr,
    output logic [7:0]  MemData,
    output logic        Busy,
    output logic        Done,
    output logic        TimedOut,
    output logic [1:0]  ProgIdx,
    output logic [15:0] CycleCnt
);

    localparam logic [7:0]  AddrLast   = 8'(PRELOAD_LEN - 1);
    localparam logic [3:0]  HoldLast   = 4'(START_CYCLES - 1);
    localparam logic [15:0] TimerLast  = 16'(TIMEOUT - 1);
    localparam state_e      FirstState = (PRELOAD_LEN > 0) ? StPreload : StStart;

    state_e      state_q, state_d;
    logic [1:0]  prog_last_q, prog_last_d;
    logic [3:0]  hold_q, hold_d;
    logic [15:0] timer_q, timer_d;

    logic        mem_we_d, start_d, busy_d, done_d, timed_out_d;
    logic [7:0]  mem_addr_d, mem_data_d;
    logic [1:0]  prog_idx_d;
    logic [15:0] cycle_cnt_d;

    logic        lfsr_load, lfsr_advance;
    logic [7:0]  lfsr_value;

    lfsr8 #(
        .SEED(SEED)
    ) u_lfsr (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Load   (lfsr_load),
        .Advance(lfsr_advance),
        .Value  (lfsr_value)
    );

    always_comb begin
        state_d     = state_q;
        prog_last_d = prog_last_q;
        prog_idx_d  = ProgIdx;
        cycle_cnt_d = CycleCnt;
        done_d      = Done;
        timed_out_d = TimedOut;

        unique case (state_q)
            StIdle: begin
                if (Go) begin
                    state_d     = FirstState;
                    prog_idx_d  = 2'd0;
                    cycle_cnt_d = 16'd0;
                    done_d      = 1'b0;
                    timed_out_d = 1'b0;
                    prog_last_d = (ProgCount == 2'd0) ? 2'd0 : ProgCount - 2'd1;
                end
            end
            StPreload: begin
                if (MemAddr == AddrLast) state_d = StStart;
            end
            StStart: begin
                if (hold_q == HoldLast) state_d = StRun;
            end
            StRun: begin
                if (CycleCnt != 16'hFFFF) cycle_cnt_d = CycleCnt + 16'd1;
                // Ack takes priority over a timeout in the same cycle
                if (Ack) begin
                    if (ProgIdx == prog_last_q) begin
                        state_d = StDone;
                    end else begin
                        prog_idx_d = ProgIdx + 2'd1;
                        state_d    = FirstState;
                    end
                end else if (timer_q == TimerLast) begin
                    state_d = StAbort;
                end
            end
            StDone, StAbort: begin
                if (!Go) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StDone) done_d = 1'b1;
        if (state_d == StAbort) timed_out_d = 1'b1;

        hold_d  = (state_d == StStart && state_q == StStart) ? hold_q + 4'd1 : 4'd0;
        timer_d = (state_d == StRun && state_q == StRun) ? timer_q + 16'd1 : 16'd0;

        // The LFSR and MemData advance together so MemData mirrors the LFSR while writing
        lfsr_load    = (state_d == StPreload) && (state_q != StPreload);
        lfsr_advance = (state_d == StPreload) && (state_q == StPreload);
        mem_we_d     = (state_d == StPreload);
        mem_addr_d   = lfsr_advance ? MemAddr + 8'd1 : 8'd0;
        mem_data_d   = lfsr_load ? SEED : (lfsr_advance ? lfsr_step(lfsr_value) : 8'h00);

        start_d = (state_d == StStart);
        busy_d  = state_d inside {StPreload, StStart, StRun};
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            prog_last_q <= 2'd0;
            hold_q      <= 4'd0;
            timer_q     <= 16'd0;
            Start       <= 1'b0;
            MemWrEn     <= 1'b0;
            MemAddr     <= 8'd0;
            MemData     <= 8'd0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            TimedOut    <= 1'b0;
            ProgIdx     <= 2'd0;
            CycleCnt    <= 16'd0;
        end else begin
            state_q     <= state_d;
            prog_last_q <= prog_last_d;
            hold_q      <= hold_d;
            timer_q     <= timer_d;
            Start       <= start_d;
            MemWrEn     <= mem_we_d;
            MemAddr     <= mem_addr_d;
            MemData     <= mem_data_d;
            Busy        <= busy_d;
            Done        <= done_d;
            TimedOut    <= timed_out_d;
            ProgIdx     <= prog_idx_d;
            CycleCnt    <= cycle_cnt_d;
        end
    end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: three instances (defaults, short timeout,
// no preload) driven through hand-computed sequences.
module tb_run_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic        go    [3];
    logic [1:0]  prog  [3];
    logic        ack   [3];
    logic        start [3];
    logic        we    [3];
    logic [7:0]  addr  [3];
    logic [7:0]  data  [3];
    logic        busy  [3];
    logic        done  [3];
    logic        tout  [3];
    logic [1:0]  idx   [3];
    logic [15:0] cyc   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    run_sequencer u_dut0 (
        .Clk(clk), .Reset_n(rst_n), .Go(go[0]), .ProgCount(prog[0]), .Ack(ack[0]),
        .Start(start[0]), .MemWrEn(we[0]), .MemAddr(addr[0]), .MemData(data[0]),
        .Busy(busy[0]), .Done(done[0]), .TimedOut(tout[0]), .ProgIdx(idx[0]),
        .CycleCnt(cyc[0])
    );

    run_sequencer #(.PRELOAD_LEN(4), .TIMEOUT(16)) u_dut1 (
        .Clk(clk), .Reset_n(rst_n), .Go(go[1]), .ProgCount(prog[1]), .Ack(ack[1]),
        .Start(start[1]), .MemWrEn(we[1]), .MemAddr(addr[1]), .MemData(data[1]),
        .Busy(busy[1]), .Done(done[1]), .TimedOut(tout[1]), .ProgIdx(idx[1]),
        .CycleCnt(cyc[1])
    );

    run_sequencer #(.PRELOAD_LEN(0)) u_dut2 (
        .Clk(clk), .Reset_n(rst_n), .Go(go[2]), .ProgCount(prog[2]), .Ack(ack[2]),
        .Start(start[2]), .MemWrEn(we[2]), .MemAddr(addr[2]), .MemData(data[2]),
        .Busy(busy[2]), .Done(done[2]), .TimedOut(tout[2]), .ProgIdx(idx[2]),
        .CycleCnt(cyc[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lfsr_model(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic check_zero(input int d);
        check("rst_we", we[d], 0);
        check("rst_addr", addr[d], 0);
        check("rst_data", data[d], 0);
        check("rst_start", start[d], 0);
        check("rst_busy", busy[d], 0);
        check("rst_done", done[d], 0);
        check("rst_tout", tout[d], 0);
        check("rst_idx", idx[d], 0);
        check("rst_cyc", cyc[d], 0);
    endtask

    // Entered on the first cycle of a program; leaves on the cycle after the
    // last RUN cycle. Go is toggled during RUN and must be ignored.
    task automatic do_round(input int d, input int len, input int run_cycles,
                            input int exp_idx, input bit give_ack);
        logic [7:0] m;
        m = 8'hA5;
        if (exp_idx == 0) begin
            check("clr_done", done[d], 0);
            check("clr_tout", tout[d], 0);
        end
        for (int i = 0; i < len; i++) begin
            check("pre_we", we[d], 1);
            check("pre_addr", addr[d], i);
            check("pre_data", data[d], m);
            check("pre_nostart", start[d], 0);
            m = lfsr_model(m);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            check("start_hi", start[d], 1);
            check("start_nowe", we[d], 0);
            check("start_busy", busy[d], 1);
            check("start_idx", idx[d], exp_idx);
            tick();
        end
        check("run_start_lo", start[d], 0);
        check("run_nowe", we[d], 0);
        check("run_busy", busy[d], 1);
        for (int j = 1; j < run_cycles; j++) begin
            go[d] = j[0];
            tick();
        end
        go[d]  = 1'b1;
        ack[d] = give_ack;
        tick();
        ack[d] = 1'b0;
    endtask

    initial begin
        logic [7:0] m;
        for (int d = 0; d < 3; d++) begin
            go[d]   = 1'b0;
            prog[d] = 2'd0;
            ack[d]  = 1'b0;
        end

        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check_zero(d);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single program, defaults, Ack on RUN cycle 10
        go[0]   = 1'b1;
        prog[0] = 2'd1;
        tick();
        do_round(0, 64, 10, 0, 1'b1);
        check("a_done", done[0], 1);
        check("a_tout", tout[0], 0);
        check("a_busy", busy[0], 0);
        check("a_idx", idx[0], 0);
        check("a_cyc", cyc[0], 10);
        tick();
        check("a_done_hold", done[0], 1);
        check("a_cyc_hold", cyc[0], 10);
        go[0] = 1'b0;
        tick();
        check("a_idle_busy", busy[0], 0);

        // Three programs, Ack on RUN cycles 5, 7, 9
        prog[0] = 2'd3;
        go[0]   = 1'b1;
        tick();
        do_round(0, 64, 5, 0, 1'b1);
        do_round(0, 64, 7, 1, 1'b1);
        do_round(0, 64, 9, 2, 1'b1);
        check("b_done", done[0], 1);
        check("b_idx", idx[0], 2);
        check("b_cyc", cyc[0], 21);
        go[0] = 1'b0;
        tick();

        // Reset pulse at preload write 20, then a clean restart
        prog[0] = 2'd1;
        go[0]   = 1'b1;
        tick();
        m = 8'hA5;
        for (int i = 0; i < 20; i++) begin
            check("e_addr", addr[0], i);
            check("e_data", data[0], m);
            m = lfsr_model(m);
            tick();
        end
        check("e_addr20", addr[0], 20);
        rst_n = 1'b0;
        #1;
        check_zero(0);
        #2 rst_n = 1'b1;
        tick();
        do_round(0, 64, 3, 0, 1'b1);
        check("e_done", done[0], 1);
        check("e_cyc", cyc[0], 3);
        go[0] = 1'b0;
        tick();

        // Timeout 16, no Ack
        prog[1] = 2'd1;
        go[1]   = 1'b1;
        tick();
        do_round(1, 4, 16, 0, 1'b0);
        check("c_tout", tout[1], 1);
        check("c_done", done[1], 0);
        check("c_start", start[1], 0);
        check("c_busy", busy[1], 0);
        check("c_cyc", cyc[1], 16);
        tick();
        check("c_tout_hold", tout[1], 1);
        check("c_cyc_hold", cyc[1], 16);
        go[1] = 1'b0;
        tick();

        // Timeout 16, Ack on RUN cycle 16 wins
        go[1] = 1'b1;
        tick();
        do_round(1, 4, 16, 0, 1'b1);
        check("d_done", done[1], 1);
        check("d_tout", tout[1], 0);
        check("d_cyc", cyc[1], 16);
        go[1] = 1'b0;
        tick();

        // No preload, ProgCount 0 runs one program
        prog[2] = 2'd0;
        go[2]   = 1'b1;
        tick();
        do_round(2, 0, 4, 0, 1'b1);
        check("f_done", done[2], 1);
        check("f_idx", idx[2], 0);
        check("f_cyc", cyc[2], 4);
        check("f_we", we[2], 0);
        go[2] = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter PRELOAD_LEN, default 64: bytes written to processor data memory before each program; 0 disables preload.
REQ-002 Parameter START_CYCLES, default 2: cycles Start is held high per program; legal range 1..15.
REQ-003 Parameter TIMEOUT, default 4096: RUN-state cycles per program before abort.
REQ-004 Parameter SEED, default 8'hA5: LFSR value loaded at each preload entry; must be non-zero.
REQ-005 Clk  in  1  single clock; all state updates on posedge.
REQ-006 Reset_n  in  1  asynchronous, active-low reset.
REQ-007 Go  in  1  level request to begin a run sequence.
REQ-008 ProgCount  in  2  programs to run back-to-back; 0 is treated as 1.
REQ-009 Ack  in  1  processor done flag; level, valid only after Start falls.
REQ-010 Start  out  1  processor start request.
REQ-011 MemWrEn  out  1  data-memory preload write enable.
REQ-012 MemAddr  out  8  preload write address.
REQ-013 MemData  out  8  preload write data.
REQ-014 Busy  out  1  high in PRELOAD, START and RUN.
REQ-015 Done  out  1  all programs acknowledged.
REQ-016 TimedOut  out  1  sequence aborted on timeout.
REQ-017 ProgIdx  out  2  index of the current or last program.
REQ-018 CycleCnt  out  16  total RUN cycles across the sequence.

Function
REQ-019 FSM states: IDLE, PRELOAD, START, RUN, DONE, ABORT; all outputs are registered.
REQ-020 IDLE: on Go=1, clear ProgIdx, CycleCnt, Done and TimedOut; go to PRELOAD if PRELOAD_LEN>0, else START.
REQ-021 PRELOAD: load LFSR with SEED on entry; assert MemWrEn for exactly PRELOAD_LEN consecutive cycles with MemAddr 0..PRELOAD_LEN-1 and MemData = current LFSR value; after the last write, go to START.
REQ-022 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts left with feedback into bit 0, advances once per write.
REQ-023 START: Start=1 for exactly START_CYCLES cycles; Ack is ignored; then go to RUN with Start=0.
REQ-024 RUN: CycleCnt increments by 1 per cycle and saturates at 16'hFFFF; the per-program timer increments from 0.
REQ-025 RUN with Ack=1 and ProgIdx = effective ProgCount-1: go to DONE; otherwise increment ProgIdx and go to PRELOAD, or to START if PRELOAD_LEN=0.
REQ-026 RUN with per-program timer = TIMEOUT-1 and Ack=0: go to ABORT.
REQ-027 Ack and timeout in the same cycle: Ack wins.
REQ-028 DONE: Done=1. ABORT: TimedOut=1. Both hold, with CycleCnt and ProgIdx frozen, until Go=0, then return to IDLE.
REQ-029 Go is ignored outside IDLE; ProgCount is sampled only on IDLE exit.
REQ-030 MemWrEn and Start are never high in the same cycle.

Reset
REQ-031 Reset_n low: state=IDLE and every output=0 immediately, without waiting for Clk; LFSR=SEED.
REQ-032 Reset mid-PRELOAD or mid-RUN aborts silently; Done and TimedOut stay 0.
REQ-033 First Go is accepted on the first posedge after Reset_n rises.

Structure
REQ-034 Package run_sequencer_pkg holds the state enum, LFSR tap mask, and default parameter constants.
REQ-035 Sub-module lfsr8 (load, advance, 8-bit value) is instantiated once.
REQ-036 Counters: address 8-bit, start-hold 4-bit, timeout 16-bit, CycleCnt 16-bit.

Verification
REQ-037 Defaults, ProgCount=1, Go=1, Ack after 10 RUN cycles -> 64 writes, addr 0..63, first data A5; Start high 2 cycles; Done=1; CycleCnt=10.
REQ-038 ProgCount=3, Ack after 5, 7 and 9 RUN cycles -> three preload+start rounds; ProgIdx ends at 2; CycleCnt=21; Done=1.
REQ-039 TIMEOUT=16, Ack never asserted -> ABORT after 16 RUN cycles; TimedOut=1; Start=0; Done=0.
REQ-040 TIMEOUT=16, Ack rises on the 16th RUN cycle -> DONE, not ABORT.
REQ-041 Reset_n pulsed low at preload write 20 -> MemWrEn and all outputs 0 asynchronously; next Go restarts at addr 0 with data A5.
REQ-042 PRELOAD_LEN=0, ProgCount=0 -> no MemWrEn; a single program runs; Go toggled during RUN is ignored.
